// File: rtl/airlock_pkg.sv
// Shared state encoding and default thresholds for the airlock controller.
package airlock_pkg;

   typedef enum logic [2:0] {
      CHECK,
      PRESSURIZED,
      DEPRESS,
      EVACUATED,
      PRESS,
      FAULT
   } airlock_state_t;

   localparam logic [7:0]  DEF_FULL_LEVEL     = 8'd28;
   localparam logic [7:0]  DEF_EMPTY_LEVEL    = 8'd0;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 64;
   localparam int unsigned TIMER_W            = 7;

   function automatic logic is_pump_state(input airlock_state_t s);
      return (s == PRESS) || (s == DEPRESS);
   endfunction

endpackage

// File: rtl/pump_timer.sv
// Saturating cycle counter for one pump phase; expired flags the cycle the count reaches the limit.
module pump_timer
   import airlock_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_CYCLES);

   logic [TIMER_W-1:0] count_d;
   logic [TIMER_W-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != '1)) begin
         count_d = count_q + TIMER_W'(1);
      end
   end

   // Looks at the count this edge will load, so the check lines up with the FSM's decision.
   assign expired = (count_d >= LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/airlock_controller.sv
// Airlock sequencer: drives the pressure unit and gates both doors on chamber pressure.
module airlock_controller
   import airlock_pkg::*;
#(
   parameter logic [7:0]  FULL_LEVEL     = DEF_FULL_LEVEL,
   parameter logic [7:0]  EMPTY_LEVEL    = DEF_EMPTY_LEVEL,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] pressure,
   input  logic       reqPressurize,
   input  logic       reqDepressurize,
   input  logic       innerDoorReq,
   input  logic       outerDoorReq,
   input  logic       innerDoorClosed,
   input  logic       outerDoorClosed,
   output logic       startPressurization,
   output logic       startDepressurization,
   output logic       innerDoorOpen,
   output logic       outerDoorOpen,
   output logic       busy,
   output logic       fault
);

   airlock_state_t state_d, state_q;
   logic start_press_d, start_press_q;
   logic start_depress_d, start_depress_q;
   logic inner_open_d, inner_open_q;
   logic outer_open_d, outer_open_q;
   logic busy_d, busy_q;
   logic fault_d, fault_q;

   logic at_full;
   logic at_empty;
   logic pump_active;
   logic timer_expired;
   logic doors_shut;

   assign at_full     = (pressure >= FULL_LEVEL);
   assign at_empty    = (pressure <= EMPTY_LEVEL);
   assign pump_active = is_pump_state(state_q);
   assign doors_shut  = innerDoorClosed && outerDoorClosed;

   // Held clear outside the pump states so each phase starts from zero without a state_d loop.
   pump_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_pump_timer (
      .clk    (clock),
      .rst    (reset),
      .clear  (!pump_active),
      .enable (pump_active),
      .expired(timer_expired)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CHECK:       state_d = at_full ? PRESSURIZED : PRESS;
         PRESSURIZED: begin
            if (reqDepressurize && !innerDoorReq && !inner_open_q && doors_shut) begin
               state_d = DEPRESS;
            end
         end
         DEPRESS: begin
            if (at_empty) begin
               state_d = EVACUATED;
            end else if (timer_expired) begin
               state_d = FAULT;
            end
         end
         EVACUATED: begin
            if (reqPressurize && !outerDoorReq && !outer_open_q && doors_shut) begin
               state_d = PRESS;
            end
         end
         PRESS: begin
            if (at_full) begin
               state_d = PRESSURIZED;
            end else if (timer_expired) begin
               state_d = FAULT;
            end
         end
         FAULT:       state_d = FAULT;
         default:     state_d = CHECK;
      endcase
   end

   // A door opens only once the idle state has been held for a full cycle.
   always_comb begin
      start_press_d   = (state_d == PRESS);
      start_depress_d = (state_d == DEPRESS);
      busy_d          = start_press_d || start_depress_d;
      fault_d         = (state_d == FAULT);
      inner_open_d    = (state_q == PRESSURIZED) && (state_d == PRESSURIZED) && innerDoorReq;
      outer_open_d    = (state_q == EVACUATED) && (state_d == EVACUATED) && outerDoorReq;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= CHECK;
         start_press_q   <= 1'b0;
         start_depress_q <= 1'b0;
         inner_open_q    <= 1'b0;
         outer_open_q    <= 1'b0;
         busy_q          <= 1'b0;
         fault_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         start_press_q   <= start_press_d;
         start_depress_q <= start_depress_d;
         inner_open_q    <= inner_open_d;
         outer_open_q    <= outer_open_d;
         busy_q          <= busy_d;
         fault_q         <= fault_d;
      end
   end

   assign startPressurization   = start_press_q;
   assign startDepressurization = start_depress_q;
   assign innerDoorOpen         = inner_open_q;
   assign outerDoorOpen         = outer_open_q;
   assign busy                  = busy_q;
   assign fault                 = fault_q;

endmodule

// File: tb/tb_airlock_controller.sv
// Randomized bench for airlock_controller against a behavioural chamber/door model.
module tb_airlock_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] pressure;
   logic       req_p, req_d, in_req, out_req, in_closed, out_closed;
   logic       start_p, start_d, inner_open, outer_open, busy, fault;

   int n_checks = 0;
   int n_errors = 0;

   // Model: has the chamber been classified, is it full, pumping direction, elapsed pump cycles.
   bit m_known, m_full, m_fault;
   int m_dir, m_cycles;
   bit e_sp, e_sd, e_in, e_out, e_busy, e_fault;
   bit stuck, glitch;

   airlock_controller dut (
      .clock                (clock),
      .reset                (reset),
      .pressure             (pressure),
      .reqPressurize        (req_p),
      .reqDepressurize      (req_d),
      .innerDoorReq         (in_req),
      .outerDoorReq         (out_req),
      .innerDoorClosed      (in_closed),
      .outerDoorClosed      (out_closed),
      .startPressurization  (start_p),
      .startDepressurization(start_d),
      .innerDoorOpen        (inner_open),
      .outerDoorOpen        (outer_open),
      .busy                 (busy),
      .fault                (fault)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (!reset) assert (!(start_p && start_d)) else $error("FAIL start_both: both start signals high");
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_known = 0; m_fault = 0; m_full = 0; m_dir = 0; m_cycles = 0;
      e_sp = 0; e_sd = 0; e_in = 0; e_out = 0; e_busy = 0; e_fault = 0;
   endtask

   task automatic model_edge();
      bit idle_full_before, idle_empty_before, idle;
      idle_full_before  = m_known && !m_fault && m_dir == 0 && m_full;
      idle_empty_before = m_known && !m_fault && m_dir == 0 && !m_full;
      if (m_fault) begin
      end else if (!m_known) begin
         m_known = 1;
         if (pressure >= 28) begin m_full = 1; m_dir = 0; end
         else begin m_dir = 1; m_cycles = 0; end
      end else if (m_dir != 0) begin
         m_cycles++;
         if ((m_dir > 0 && pressure >= 28) || (m_dir < 0 && pressure == 0)) begin
            m_full = (m_dir > 0);
            m_dir  = 0;
         end else if (m_cycles >= 64) begin
            m_fault = 1;
         end
      end else if (m_full) begin
         if (req_d && !in_req && !e_in && in_closed && out_closed) begin m_dir = -1; m_cycles = 0; end
      end else begin
         if (req_p && !out_req && !e_out && in_closed && out_closed) begin m_dir = 1; m_cycles = 0; end
      end
      idle    = m_known && !m_fault && m_dir == 0;
      e_fault = m_fault;
      e_sp    = !m_fault && m_dir > 0;
      e_sd    = !m_fault && m_dir < 0;
      e_busy  = e_sp || e_sd;
      e_in    = idle_full_before && idle && m_full && in_req;
      e_out   = idle_empty_before && idle && !m_full && out_req;
   endtask

   // One clock: model follows the edge, outputs checked 1ns later, then the chamber reacts.
   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      check_eq("start_p", start_p, e_sp);
      check_eq("start_d", start_d, e_sd);
      check_eq("inner_open", inner_open, e_in);
      check_eq("outer_open", outer_open, e_out);
      check_eq("busy", busy, e_busy);
      check_eq("fault", fault, e_fault);
      check_eq("start_excl", start_p && start_d, 1'b0);
      if (!stuck) begin
         if (e_sp && pressure < 8'd40) pressure = pressure + 8'd1;
         else if (e_sd && pressure > 8'd0) pressure = pressure - 8'd1;
      end
      req_p = 0;
      req_d = 0;
      in_closed  = !e_in && !(glitch && $urandom_range(7) == 0);
      out_closed = !e_out && !(glitch && $urandom_range(7) == 0);
   endtask

   task automatic do_reset();
      reset = 1;
      #1;
      check_eq("rst_start_p", start_p, 1'b0);
      check_eq("rst_start_d", start_d, 1'b0);
      check_eq("rst_inner", inner_open, 1'b0);
      check_eq("rst_outer", outer_open, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_fault", fault, 1'b0);
      model_reset();
      stuck = 0;
      #2;
      reset = 0;
   endtask

   task automatic run_until_idle(input string tag, input int max_cycles);
      for (int i = 0; i < max_cycles && e_busy; i++) step();
      check_eq(tag, busy, 1'b0);
   endtask

   initial begin
      reset = 1; pressure = 8'd28; req_p = 0; req_d = 0;
      in_req = 1; out_req = 0; in_closed = 1; out_closed = 1;
      stuck = 0; glitch = 0;
      model_reset();
      #2;
      check_eq("reset_state_busy", busy, 1'b0);
      check_eq("reset_state_inner", inner_open, 1'b0);
      reset = 0;

      // CHECK -> PRESSURIZED, inner door follows its request one edge later
      step();
      step();
      check_eq("inner_opens", inner_open, 1'b1);
      in_req = 0;
      repeat (3) step();

      // Depressurize 28 -> 0
      req_d = 1;
      step();
      check_eq("depress_started", start_d, 1'b1);
      run_until_idle("depress_done", 60);

      // EVACUATED with outer request held: pressurize request ignored
      out_req = 1;
      repeat (2) step();
      req_p = 1;
      step();
      check_eq("press_ignored", start_p, 1'b0);
      out_req = 0;
      repeat (3) step();

      // PRESS with pressure stuck at 10 -> timeout fault
      req_p = 1;
      step();
      for (int i = 0; i < 40 && pressure != 8'd10; i++) step();
      stuck = 1;
      for (int i = 0; i < 80; i++) begin
         req_p = ($urandom_range(3) == 0);
         req_d = ($urandom_range(3) == 0);
         step();
      end
      check_eq("timeout_fault", fault, 1'b1);
      check_eq("fault_no_start", start_p, 1'b0);

      // Reset out of FAULT at pressure 10: CHECK -> PRESS, pump back to 28
      do_reset();
      step();
      check_eq("recheck_press", start_p, 1'b1);
      run_until_idle("repress_done", 60);
      check_eq("repress_level", pressure, 8'd28);
      repeat (2) step();

      // Reset mid-DEPRESS at pressure 12
      req_d = 1;
      step();
      for (int i = 0; i < 40 && pressure != 8'd12; i++) step();
      check_eq("depress_at_12", start_d, 1'b1);
      do_reset();
      step();
      check_eq("after_rst_press", start_p, 1'b1);
      run_until_idle("after_rst_done", 60);
      repeat (2) step();

      // Both requests at once in PRESSURIZED: only depressurize acts
      req_p = 1;
      req_d = 1;
      step();
      check_eq("both_req_depress", start_d, 1'b1);
      check_eq("both_req_press", start_p, 1'b0);
      run_until_idle("both_req_done", 60);

      // Random phase
      glitch = 1;
      for (int i = 0; i < 2500; i++) begin
         req_p = ($urandom_range(5) == 0);
         req_d = ($urandom_range(5) == 0);
         if ($urandom_range(9) == 0) in_req = ~in_req;
         if ($urandom_range(9) == 0) out_req = ~out_req;
         if (e_busy && $urandom_range(255) == 0) stuck = 1;
         if ((e_fault && $urandom_range(15) == 0) || $urandom_range(499) == 0) begin
            if ($urandom_range(1) == 0) pressure = 8'($urandom_range(40));
            do_reset();
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/airlock_controller.md
# airlock_controller

Control end of the airlock pressure interface. It issues `startPressurization` / `startDepressurization` to the chamber pressure unit and watches the 8-bit `pressure` it returns. It sequences the inner and outer doors so that a door opens only at a safe pressure, and it flags a fault if a pump phase overruns. The block sits between the operator/door request logic and the pressure unit.

## Interface
- `FULL_LEVEL`, 8'd28: pressure at or above this counts as pressurized.
- `EMPTY_LEVEL`, 8'd0: pressure at or below this counts as evacuated.
- `TIMEOUT_CYCLES`, 64: maximum cycles allowed in one pump phase.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pressure`  in  8  chamber pressure from the pressure unit.
- `reqPressurize`  in  1  single-cycle request to pressurize.
- `reqDepressurize`  in  1  single-cycle request to evacuate.
- `innerDoorReq`  in  1  level; hold the inner door open while high.
- `outerDoorReq`  in  1  level; hold the outer door open while high.
- `innerDoorClosed`  in  1  sensor; inner door fully shut.
- `outerDoorClosed`  in  1  sensor; outer door fully shut.
- `startPressurization`  out  1  level to the pressure unit.
- `startDepressurization`  out  1  level to the pressure unit.
- `innerDoorOpen`  out  1  inner door actuator.
- `outerDoorOpen`  out  1  outer door actuator.
- `busy`  out  1  a pump phase is in progress.
- `fault`  out  1  sticky timeout flag.

## Operation
- States:
  - CHECK: reset state.
  - PRESSURIZED
  - DEPRESS
  - EVACUATED
  - PRESS
  - FAULT
- CHECK: next cycle go to PRESSURIZED if `pressure >= FULL_LEVEL`, else go to PRESS. CHECK itself drives nothing.
- PRESSURIZED:
  - `innerDoorOpen = innerDoorReq`.
  - `reqDepressurize` is accepted only if `innerDoorReq`=0, `innerDoorOpen`=0, `innerDoorClosed`=1 and `outerDoorClosed`=1. Otherwise it is dropped; requests are not queued.
  - Accepted request -> DEPRESS.
- DEPRESS:
  - Both doors closed; `startDepressurization`=1; `busy`=1.
  - `pressure <= EMPTY_LEVEL` -> EVACUATED.
- EVACUATED: mirror of PRESSURIZED, using the outer door and `reqPressurize`. Accepted request -> PRESS.
- PRESS:
  - Both doors closed; `startPressurization`=1; `busy`=1.
  - `pressure >= FULL_LEVEL` -> PRESSURIZED.
- Pump timer: cleared on entry to DEPRESS or PRESS and incremented each cycle in those states. If it reaches `TIMEOUT_CYCLES` before the target pressure -> FAULT.
- FAULT: all actuators 0, `fault`=1. Only `reset` leaves FAULT.
- Request rules:
  - A request that does not match the current idle state is ignored; e.g. `reqPressurize` in PRESSURIZED is ignored.
  - All requests are ignored in pump states, CHECK and FAULT.
  - Both requests in the same cycle: only the applicable one acts.
- Target reached on the same cycle the timer expires: the target wins and there is no fault.
- Start signals are never both 1; this is an assertion in the bench.

## Timing
- All outputs are registered and decoded from the next-state.
- Reset value of every output is 0; the state resets to CHECK and the timer to 0.
- Request accepted at edge N: `startX`=1 and `busy`=1 from edge N, and the door output is already 0.
- Pressure meets the threshold, sampled at edge M: `startX`=0 and `busy`=0 after edge M. The door may open at edge M+1 if its request is high.
- Door request falls: the door output drops at the next edge. A pump request is accepted no earlier than the edge after the door output reads 0 and its closed sensor is 1.
- Reset mid-pump: outputs clear asynchronously and the block re-enters CHECK.
- The timer is 7 bits wide and saturates; it does not wrap.

## Structure
- Package `airlock_pkg`:
  - State enum: CHECK, PRESSURIZED, DEPRESS, EVACUATED, PRESS, FAULT.
  - Default level constants and the default timeout.
- Sub-module `pump_timer`:
  - Inputs: clear, enable.
  - Output: `expired` at `TIMEOUT_CYCLES`.
  - Asynchronous reset.

## Test plan
- Reset with `pressure`=28 -> CHECK then PRESSURIZED; all outputs 0; `innerDoorReq`=1 -> `innerDoorOpen`=1 one edge later.
- PRESSURIZED with doors closed, `reqDepressurize` pulse, model counting down 28->0 -> `startDepressurization` high ~28 cycles, then EVACUATED, `busy`=0.
- EVACUATED, `reqPressurize` with `outerDoorReq`=1 held -> ignored; `startPressurization` stays 0.
- PRESS with the pressure model stuck at 10 -> `fault`=1 after 64 cycles; starts 0; requests ignored until reset.
- Assert `reset` mid-DEPRESS at `pressure`=12 -> outputs 0 immediately; CHECK -> PRESS; pumps back to 28.
- `reqPressurize` and `reqDepressurize` in the same cycle in PRESSURIZED -> depressurize only; start signals never both 1.
